// File: rtl/uart_mem_pkg.sv
// Shared constants and state encoding for the UART-to-RAM image loader.
package uart_mem_pkg;

  localparam int unsigned RAM_DEPTH      = 5320;
  localparam int unsigned RAM_AW         = 13;
  localparam int unsigned RAM_DW         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned MAX_LOAD_BYTES = RAM_DEPTH * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/uart_byte_packer.sv
// Little-endian byte-to-word packer: lane buffer, written-lane mask and lane index.
module uart_byte_packer
  import uart_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  output logic [RAM_DW-1:0] word_o,
  output logic [3:0]        mask_o,
  output logic              word_full_o
);

  logic [RAM_DW-1:0] buf_q, buf_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    buf_d  = buf_q;
    mask_d = mask_q;
    idx_d  = idx_q;
    if (clear_i) begin
      buf_d  = '0;
      mask_d = '0;
      idx_d  = '0;
    end else if (accept_i) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (idx_q == i[1:0]) begin
          buf_d[8*i +: 8] = byte_i;
          mask_d[i]       = 1'b1;
        end
      end
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      mask_q <= '0;
      idx_q  <= '0;
    end else begin
      buf_q  <= buf_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = buf_q;
  assign mask_o      = mask_q;
  assign word_full_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a UART byte stream into on-chip RAM as little-endian 32-bit words from word 0.
module uart_mem_loader
  import uart_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RAM_DW,
  parameter int unsigned ADDR_WIDTH = RAM_AW,
  parameter int unsigned DEPTH      = RAM_DEPTH,
  parameter int unsigned LEN_WIDTH  = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  output logic                  busy,
  output logic                  done,
  output logic                  len_error
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DEPTH * BYTES_PER_WORD);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
  logic                  len_err_q, len_err_d;

  logic                  pk_clear;
  logic                  accept;
  logic                  word_full;
  logic [RAM_DW-1:0]     pk_word;
  logic [3:0]            pk_mask;

  assign accept = in_valid && (state_q == FILL);

  uart_byte_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (pk_clear),
    .accept_i    (accept),
    .byte_i      (in_data),
    .word_o      (pk_word),
    .mask_o      (pk_mask),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_addr_d = word_addr_q;
    addr_out_d  = addr_out_q;
    len_err_d   = len_err_q;
    pk_clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = DONE;
          end else if (length > MAX_LEN) begin
            len_err_d = 1'b1;
          end else begin
            len_err_d   = 1'b0;
            remaining_d = length;
            word_addr_d = '0;
            pk_clear    = 1'b1;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          remaining_d = remaining_q - 1'b1;
          if (word_full || (remaining_q == LEN_WIDTH'(1))) begin
            // Latch the target address on entry so mem_address holds it after the write.
            addr_out_d = word_addr_q;
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        pk_clear    = 1'b1;
        word_addr_d = word_addr_q + 1'b1;
        state_d     = (remaining_q == '0) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      word_addr_q <= '0;
      addr_out_q  <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_addr_q <= word_addr_d;
      addr_out_q  <= addr_out_d;
      len_err_q   <= len_err_d;
    end
  end

  assign in_ready       = (state_q == FILL);
  assign busy           = (state_q == FILL) || (state_q == WRITE);
  assign done           = (state_q == DONE);
  assign len_error      = len_err_q;
  assign mem_chipselect = (state_q == WRITE);
  assign mem_write      = (state_q == WRITE);
  assign mem_clken      = 1'b1;
  assign mem_address    = addr_out_q;
  assign mem_writedata  = (state_q == WRITE) ? DATA_WIDTH'(pk_word) : '0;
  assign mem_byteenable = (state_q == WRITE) ? pk_mask : '0;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader with a byte-lane RAM model and write log.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] length = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic        busy;
  logic        done;
  logic        len_error;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (13),
    .DEPTH      (5320),
    .LEN_WIDTH  (15)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .length         (length),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .len_error      (len_error)
  );

  typedef struct packed {
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    int unsigned len;
    int unsigned gap;
    logic [7:0]  first;
    logic [7:0]  step;
    int unsigned nwr;
    logic [31:0] w0;
    logic [3:0]  be0;
    logic [31:0] wl;
    logic [3:0]  bel;
    logic [31:0] ram1;
  } vec_t;

  wr_t         wq[$];
  logic [31:0] ram[0:5319];
  int unsigned done_cnt = 0;
  int unsigned overlap  = 0;
  int unsigned total    = 0;
  int unsigned bad      = 0;

  always @(negedge clk) begin
    if (mem_chipselect && mem_write) begin
      wq.push_back('{a: mem_address, d: mem_writedata, be: mem_byteenable});
      for (int k = 0; k < 4; k++)
        if (mem_byteenable[k]) ram[mem_address][8*k +: 8] = mem_writedata[8*k +: 8];
      if (in_ready) overlap++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input int unsigned len, input int unsigned gap,
                          input logic [7:0] first, input logic [7:0] step,
                          input int unsigned budget);
    int unsigned sent = 0;
    int unsigned wait_cnt = 0;
    int unsigned cyc = 0;
    int unsigned d0;
    logic        rdy = 1'b0;
    logic [7:0]  b;
    d0 = done_cnt;
    b  = first;
    @(negedge clk);
    start  = 1'b1;
    length = len[14:0];
    @(negedge clk);
    start = 1'b0;
    while (done_cnt == d0 && cyc < budget) begin
      if (in_valid && rdy) begin
        sent++;
        b = b + step;
        wait_cnt = gap;
      end
      if (sent < len && wait_cnt == 0) begin
        in_valid = 1'b1;
        in_data  = b;
      end else begin
        in_valid = 1'b0;
        if (wait_cnt > 0) wait_cnt--;
      end
      rdy = in_ready;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("bytes_sent", sent, len);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
  endtask

  vec_t        vecs[5];
  int unsigned base, n, bad_addr, w0cnt, d0;

  initial begin
    vecs[0] = '{8,     0, 8'h11, 8'h11, 2,    32'h44332211, 4'hF, 32'h88776655, 4'hF, 32'h88776655};
    vecs[1] = '{6,     0, 8'hA0, 8'h01, 2,    32'hA3A2A1A0, 4'hF, 32'h0000A5A4, 4'h3, 32'hCAFEA5A4};
    vecs[2] = '{4,     2, 8'h10, 8'h01, 1,    32'h13121110, 4'hF, 32'h13121110, 4'hF, 32'hCAFEF00D};
    vecs[3] = '{7,     1, 8'h01, 8'h01, 2,    32'h04030201, 4'hF, 32'h00070605, 4'h7, 32'hCA070605};
    vecs[4] = '{21280, 0, 8'h00, 8'h01, 5320, 32'h03020100, 4'hF, 32'h1F1E1D1C, 4'hF, 32'h07060504};

    in_valid = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", {mem_chipselect, mem_write}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_writedata, 0);
    check("rst_be", mem_byteenable, 0);
    check("rst_clken", mem_clken, 1);
    check("rst_len_error", len_error, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // over-length request
    start = 1'b1; length = 15'd21281;
    @(negedge clk);
    start = 1'b0;
    check("lenerr_set", len_error, 1);
    check("lenerr_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("lenerr_idle", {busy, in_ready}, 0);
    check("lenerr_nowrite", wq.size(), 0);

    // zero-length request
    d0 = done_cnt;
    start = 1'b1; length = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    @(negedge clk);
    check("len0_done_drop", done, 0);
    check("len0_pulses", done_cnt - d0, 1);
    check("len0_nowrite", wq.size(), 0);
    check("len0_err_sticky", len_error, 1);

    for (int i = 0; i < 5; i++) begin
      base = wq.size();
      ram[1] = 32'hCAFEF00D;
      run_load(vecs[i].len, vecs[i].gap, vecs[i].first, vecs[i].step, vecs[i].len * 5 + 50);
      n = wq.size() - base;
      check($sformatf("v%0d_nwr", i), n, vecs[i].nwr);
      check($sformatf("v%0d_len_error", i), len_error, 0);
      if (n > 0) begin
        bad_addr = 0;
        for (int j = 0; j < int'(n); j++)
          if (wq[base + j].a != 13'(j)) bad_addr++;
        check($sformatf("v%0d_addr_seq", i), bad_addr, 0);
        check($sformatf("v%0d_w0", i), wq[base].d, vecs[i].w0);
        check($sformatf("v%0d_be0", i), wq[base].be, vecs[i].be0);
        check($sformatf("v%0d_wl", i), wq[base + n - 1].d, vecs[i].wl);
        check($sformatf("v%0d_bel", i), wq[base + n - 1].be, vecs[i].bel);
        check($sformatf("v%0d_last_addr", i), wq[base + n - 1].a, vecs[i].nwr - 1);
      end
      check($sformatf("v%0d_ram1", i), ram[1], vecs[i].ram1);
      check($sformatf("v%0d_busy_end", i), busy, 0);
    end

    // reset mid-load after 3 of 4 bytes
    base = wq.size();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; length = 15'd4;
    @(negedge clk);
    start = 1'b0;
    check("mid_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h31;
    @(negedge clk);
    in_data = 8'h32;
    @(negedge clk);
    in_data = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", {in_ready, busy, done, mem_chipselect, mem_write, len_error}, 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_wdata", mem_writedata, 0);
    check("mid_rst_be", mem_byteenable, 0);
    check("mid_rst_clken", mem_clken, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_nowrite", wq.size() - base, 0);
    check("mid_nodone", done_cnt - d0, 0);
    run_load(4, 0, 8'hC0, 8'h01, 60);
    n = wq.size() - base;
    check("post_nwr", n, 1);
    if (n > 0) begin
      check("post_addr", wq[base].a, 0);
      check("post_data", wq[base].d, 32'hC3C2C1C0);
      check("post_be", wq[base].be, 4'hF);
    end

    check("ready_during_write", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
